// File: rtl/stack_ops_pkg.sv
// Shared opcode encodings, per-op stack pop/push counts and sequencer state type.
// Tables are indexed directly by the 4-bit opcode; illegal codes read as zero work.
package stack_ops_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_PUSH = 4'd1,
        OP_POP  = 4'd2,
        OP_DUP  = 4'd3,
        OP_SWAP = 4'd4,
        OP_ADD  = 4'd5,
        OP_SUB  = 4'd6,
        OP_AND  = 4'd7,
        OP_OR   = 4'd8,
        OP_XOR  = 4'd9
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_PUSH1,
        S_PUSH2,
        S_FIN
    } state_t;

    // Entries listed from opcode 15 down to opcode 0.
    localparam logic [15:0][1:0] POP_TBL = {
        2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd2, 2'd0, 2'd1, 2'd0, 2'd0
    };

    localparam logic [15:0][1:0] PUSH_TBL = {
        2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
        2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
        2'd2, 2'd1, 2'd0, 2'd1, 2'd0
    };

    localparam logic [15:0] OP_LEGAL = 16'h03FF;

endpackage

// File: rtl/stack_alu.sv
// Combinational data path: value for the first push of an operation.
// No latency, no handshake; SWAP yields A here, its second push (B) comes from the sequencer.
module stack_alu
    import stack_ops_pkg::*;
#(
    parameter int WIDTH = 31
) (
    input  logic [3:0]     op,
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic [WIDTH:0] imm,
    output logic [WIDTH:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_PUSH: result = imm;
            OP_DUP:  result = a;
            OP_SWAP: result = a;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/stack_sequencer.sv
// Sequences stack operations into one pop cycle then push cycles, ending with a done pulse.
// Latency: done at T+1 (NOP/rejected) up to T+4 (SWAP); op_ready only in IDLE, op_valid ignored otherwise.
module stack_sequencer
    import stack_ops_pkg::*;
#(
    parameter int DEPTH = 127,
    parameter int WIDTH = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [3:0]               op_code,
    input  logic [WIDTH:0]           op_imm,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     stk_push,
    output logic [WIDTH:0]           stk_push_data,
    output logic [2:0]               stk_pop,
    input  logic [WIDTH:0]           stk_preview0,
    input  logic [WIDTH:0]           stk_preview1
);

    localparam int DW = $clog2(DEPTH) + 1;
    localparam int XW = DW + 2;

    state_t         state, state_nxt;
    logic [3:0]     op_q;
    logic [WIDTH:0] imm_q, a_q, b_q, alu_res;
    logic           rej_q;
    logic [1:0]     in_pops, in_pushes, pops_q, pushes_q;
    logic [XW-1:0]  depth_x;
    logic           accept, reject;

    assign in_pops   = POP_TBL[op_code];
    assign in_pushes = PUSH_TBL[op_code];
    assign pops_q    = POP_TBL[op_q];
    assign pushes_q  = PUSH_TBL[op_q];
    assign accept    = op_valid && (state == S_IDLE);
    assign depth_x   = XW'(depth);

    // Overflow test rearranged as depth + pushes > DEPTH + pops to stay unsigned.
    assign reject = !OP_LEGAL[op_code]
                 || (depth_x < XW'(in_pops))
                 || ((depth_x + XW'(in_pushes)) > (XW'(DEPTH) + XW'(in_pops)));

    stack_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .imm    (imm_q),
        .result (alu_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            depth <= '0;
            op_q  <= '0;
            imm_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rej_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= op_code;
                imm_q <= op_imm;
                a_q   <= stk_preview0;
                b_q   <= stk_preview1;
                rej_q <= reject;
            end
            case (state)
                S_POP:            depth <= depth - DW'(pops_q);
                S_PUSH1, S_PUSH2: depth <= depth + DW'(1);
                default:          depth <= depth;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        op_ready      = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        stk_push      = 1'b0;
        stk_pop       = '0;
        stk_push_data = '0;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    if (reject || (in_pops == 2'd0 && in_pushes == 2'd0))
                        state_nxt = S_FIN;
                    else if (in_pops != 2'd0)
                        state_nxt = S_POP;
                    else
                        state_nxt = S_PUSH1;
                end
            end
            S_POP: begin
                stk_pop   = {1'b0, pops_q};
                state_nxt = (pushes_q != 2'd0) ? S_PUSH1 : S_FIN;
            end
            S_PUSH1: begin
                stk_push      = 1'b1;
                stk_push_data = alu_res;
                state_nxt     = (pushes_q == 2'd2) ? S_PUSH2 : S_FIN;
            end
            S_PUSH2: begin
                stk_push      = 1'b1;
                stk_push_data = b_q;
                state_nxt     = S_FIN;
            end
            S_FIN: begin
                done      = 1'b1;
                err       = rej_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
